// File: rtl/ahb_mux_pkg.sv
// rtl/ahb_mux_pkg.sv - shared encodings for the AHB slave-to-master response mux
package ahb_mux_pkg;

    localparam int NUM_SLV = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        DSEL_S0   = 3'd0,
        DSEL_S1   = 3'd1,
        DSEL_S2   = 3'd2,
        DSEL_S3   = 3'd3,
        DSEL_DEF  = 3'd4,
        DSEL_NONE = 3'd5
    } dsel_e;

    typedef logic [1:0] ds_state_t;

    localparam ds_state_t DS_IDLE = 2'd0;
    localparam ds_state_t DS_ERR1 = 2'd1;
    localparam ds_state_t DS_ERR2 = 2'd2;

    function automatic dsel_e slave_dsel(input logic [1:0] idx);
        return dsel_e'({1'b0, idx});
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - two-cycle ERROR responder for unmapped active transfers
module ahb_default_slave
    import ahb_mux_pkg::*;
(
    input  logic hclk,
    input  logic hresetn,
    input  logic start,
    input  logic hready,
    output logic hreadyout,
    output logic hresp
);

    ds_state_t state_q, state_d;

    // start only counts on edges where the address phase is actually accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (start && hready) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = (start && hready) ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) state_q <= DS_IDLE;
        else          state_q <= state_d;
    end

    assign hreadyout = (state_q != DS_ERR1);
    assign hresp     = ((state_q == DS_ERR1) || (state_q == DS_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - address decode, data-phase select and response mux (AHB_RESP_MUX_DEFSLV_EN enables the default slave)
module ahb_resp_mux
    import ahb_mux_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEC_LSB = 28
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    output logic [3:0]        hsel_s,
    input  logic [DATA_W-1:0] hrdata_s0,
    input  logic [DATA_W-1:0] hrdata_s1,
    input  logic [DATA_W-1:0] hrdata_s2,
    input  logic [DATA_W-1:0] hrdata_s3,
    input  logic [3:0]        hreadyout_s,
    input  logic [3:0]        hresp_s,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    output logic              hresp
);

    logic [3:0] region;
    logic       mapped;
    dsel_e      dsel_q, dsel_d;
    dsel_e      dsel_load;
    logic       unused_ok;

    assign region    = haddr[DEC_LSB+3:DEC_LSB];
    assign mapped    = (region[3:2] == 2'b00);
    assign hsel_s    = mapped ? (4'b0001 << region[1:0]) : 4'b0000;
    assign unused_ok = ^{haddr, htrans};

`ifdef AHB_RESP_MUX_DEFSLV_EN
    logic active;
    logic def_hreadyout;
    logic def_hresp;

    assign active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

    ahb_default_slave u_default_slave (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .start     (!mapped && active),
        .hready    (hready),
        .hreadyout (def_hreadyout),
        .hresp     (def_hresp)
    );

    always_comb begin
        dsel_load = DSEL_NONE;
        if (mapped)      dsel_load = slave_dsel(region[1:0]);
        else if (active) dsel_load = DSEL_DEF;
    end
`else
    always_comb begin
        dsel_load = DSEL_NONE;
        if (mapped) dsel_load = slave_dsel(region[1:0]);
    end
`endif

    // the data-phase owner only advances when the current data phase completes
    assign dsel_d = hready ? dsel_load : dsel_q;

    always_ff @(posedge hclk) begin
        if (!hresetn) dsel_q <= DSEL_NONE;
        else          dsel_q <= dsel_d;
    end

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        case (dsel_q)
            DSEL_S0: begin hrdata = hrdata_s0; hready = hreadyout_s[0]; hresp = hresp_s[0]; end
            DSEL_S1: begin hrdata = hrdata_s1; hready = hreadyout_s[1]; hresp = hresp_s[1]; end
            DSEL_S2: begin hrdata = hrdata_s2; hready = hreadyout_s[2]; hresp = hresp_s[2]; end
            DSEL_S3: begin hrdata = hrdata_s3; hready = hreadyout_s[3]; hresp = hresp_s[3]; end
`ifdef AHB_RESP_MUX_DEFSLV_EN
            DSEL_DEF: begin hready = def_hreadyout; hresp = def_hresp; end
`endif
            default: ;
        endcase
    end

endmodule
